// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEFAULT = 16;

    typedef enum logic [1:0] {IDLE, RD, PUSH, WR} state_t;
    typedef enum logic {SRC_I, SRC_D} src_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-ported memory.
// Define ARB_RR_EN to alternate grants on ties instead of fixed data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_req_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_req_addr,
    output logic          d_gnt,
    output logic          d_done,
    output logic          m_d_read,
    output logic          m_d_write,
    output logic          m_d_push,
    output logic          m_i_read,
    output logic          m_i_push,
    output logic [AW-1:0] m_d_addr,
    output logic [AW-1:0] m_i_addr,
    output logic          busy
);

    state_t state_reg;
    src_t   src_reg;
    logic   we_reg;
    logic   pick_d;

`ifdef ARB_RR_EN
    src_t last_src_reg;

    // On a tie the side that was not granted last wins.
    assign pick_d = d_req && (!i_req || (last_src_reg == SRC_I));
`else
    assign pick_d = d_req;
`endif

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            src_reg   <= SRC_I;
            we_reg    <= 1'b0;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_done    <= 1'b0;
            m_d_read  <= 1'b0;
            m_d_write <= 1'b0;
            m_d_push  <= 1'b0;
            m_i_read  <= 1'b0;
            m_i_push  <= 1'b0;
            m_d_addr  <= '0;
            m_i_addr  <= '0;
`ifdef ARB_RR_EN
            last_src_reg <= SRC_I;
`endif
        end else begin
            // Every control output is a single-cycle pulse.
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_done    <= 1'b0;
            m_d_read  <= 1'b0;
            m_d_write <= 1'b0;
            m_d_push  <= 1'b0;
            m_i_read  <= 1'b0;
            m_i_push  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (pick_d) begin
                            d_gnt     <= 1'b1;
                            src_reg   <= SRC_D;
                            we_reg    <= d_we;
                            m_d_addr  <= d_req_addr;
                            state_reg <= d_we ? WR : RD;
                        end else begin
                            i_gnt     <= 1'b1;
                            src_reg   <= SRC_I;
                            we_reg    <= 1'b0;
                            m_i_addr  <= i_req_addr;
                            state_reg <= RD;
                        end
`ifdef ARB_RR_EN
                        last_src_reg <= pick_d ? SRC_D : SRC_I;
`endif
                    end
                end
                RD: begin
                    if (src_reg == SRC_D) begin
                        m_d_read <= !we_reg;
                    end else begin
                        m_i_read <= 1'b1;
                    end
                    state_reg <= PUSH;
                end
                PUSH: begin
                    if (src_reg == SRC_D) begin
                        m_d_push <= 1'b1;
                        d_done   <= 1'b1;
                    end else begin
                        m_i_push <= 1'b1;
                        i_rvalid <= 1'b1;
                    end
                    state_reg <= IDLE;
                end
                WR: begin
                    m_d_write <= 1'b1;
                    d_done    <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
